// File: rtl/pe_accumulator_pkg.sv
// Shared definitions for the PE accumulator: default widths, FSM states and
// the saturating clamp used by both the multiplier and the accumulator.
package pe_accumulator_pkg;

  localparam int RESULT_WIDTH  = 16;
  localparam int ACC_GUARD     = 8;
  localparam int LEN_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_e;

  // Clamps a sign-extended value to the signed range of 'width' bits.
  // The bounds are symmetric in form: MAX={0,1..1} and MIN={1,0..0}.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] value,
                                                   input int width);
    logic signed [63:0] max_val;
    logic signed [63:0] min_val;
    max_val = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_val = -(64'sd1 <<< (width - 1));
    if (value > max_val) return max_val;
    if (value < min_val) return min_val;
    return value;
  endfunction

endpackage

// File: rtl/pe_accumulator_sat_adder.sv
// Combinational signed add with saturation to the operand width; ovf flags a clamp.
module sat_adder
  import pe_accumulator_pkg::*;
#(
  parameter int WIDTH = RESULT_WIDTH + ACC_GUARD
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] sum,
  output logic                    ovf
);

  logic signed [63:0] wide_sum;
  logic signed [63:0] clamped;

  always_comb begin
    wide_sum = {{(64-WIDTH){a[WIDTH-1]}}, a} + {{(64-WIDTH){b[WIDTH-1]}}, b};
    clamped  = sat_clamp(wide_sum, WIDTH);
    sum      = clamped[WIDTH-1:0];
    ovf      = (clamped != wide_sum);
  end

endmodule

// File: rtl/pe_accumulator.sv
// Sums LEN consecutive multiplier products into a guarded accumulator and hands
// one saturated dot-product result downstream over valid/ready.
module pe_accumulator
  import pe_accumulator_pkg::*;
#(
  parameter int IN_WIDTH  = RESULT_WIDTH,
  parameter int OUT_WIDTH = RESULT_WIDTH,
  parameter int GUARD     = ACC_GUARD,
  parameter int LEN_WIDTH = LEN_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic [IN_WIDTH-1:0]  prod_in,
  input  logic                 prod_valid,
  output logic                 stall_out,
  output logic [OUT_WIDTH-1:0] res_out,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 sat_flag,
  output logic                 busy
);

  localparam int ACC_WIDTH = OUT_WIDTH + GUARD;

  acc_state_e state, state_next;

  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] add_sum;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic                        add_ovf;
  logic [LEN_WIDTH-1:0]        count;
  logic [LEN_WIDTH-1:0]        count_next;
  logic [LEN_WIDTH-1:0]        len_eff;
  logic [LEN_WIDTH-1:0]        len_next;
  logic                        accept;
  logic                        start;
  logic                        last;
  logic signed [63:0]          acc_wide;
  logic signed [63:0]          res_wide;
  logic [OUT_WIDTH-1:0]        res_next;
  logic                        fin_ovf;

  assign prod_ext  = {{(ACC_WIDTH-IN_WIDTH){prod_in[IN_WIDTH-1]}}, prod_in};
  assign stall_out = (state == HOLD) && !res_ready;
  assign accept    = prod_valid && !stall_out && !clear;
  assign start     = accept && (state != ACCUM);
  assign res_valid = (state == HOLD);
  assign busy      = (state != IDLE);

  sat_adder #(.WIDTH(ACC_WIDTH)) u_sat_adder (
    .a   (acc),
    .b   (prod_ext),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // A term arriving in IDLE, or alongside a HOLD handshake, opens a new vector.
  always_comb begin
    len_next   = start ? ((len == '0) ? LEN_WIDTH'(1) : len) : len_eff;
    count_next = start ? LEN_WIDTH'(1) : count + LEN_WIDTH'(1);
    last       = accept && (count_next == len_next);
    acc_next   = start ? prod_ext : add_sum;
    acc_wide   = {{(64-ACC_WIDTH){acc_next[ACC_WIDTH-1]}}, acc_next};
    res_wide   = sat_clamp(acc_wide, OUT_WIDTH);
    res_next   = res_wide[OUT_WIDTH-1:0];
    fin_ovf    = (res_wide != acc_wide);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, ACCUM: if (accept) state_next = last ? HOLD : ACCUM;
      HOLD:        if (res_ready) state_next = accept ? (last ? HOLD : ACCUM) : IDLE;
      default:     state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      acc      <= '0;
      count    <= '0;
      len_eff  <= '0;
      res_out  <= '0;
      sat_flag <= 1'b0;
    end else if (clear) begin
      state    <= IDLE;
      acc      <= '0;
      count    <= '0;
      sat_flag <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        acc      <= acc_next;
        count    <= count_next;
        len_eff  <= len_next;
        sat_flag <= (!start && (sat_flag || add_ovf)) || (last && fin_ovf);
        if (last) res_out <= res_next;
      end
    end
  end

endmodule

// File: tb/tb_pe_accumulator.sv
// Directed self-checking bench for pe_accumulator in Q8.8 (16-bit result, 8 guard bits).
module tb_pe_accumulator;

  logic        clk;
  logic        reset;
  logic        clear;
  logic [7:0]  len;
  logic [15:0] prod_in;
  logic        prod_valid;
  logic        stall_out;
  logic [15:0] res_out;
  logic        res_valid;
  logic        res_ready;
  logic        sat_flag;
  logic        busy;

  int vectors_applied = 0;
  int miscompares     = 0;

  typedef struct packed {
    logic [7:0]       len;
    logic [2:0]       n;
    logic [3:0][15:0] terms;
    logic [15:0]      exp_res;
    logic             exp_sat;
  } vec_t;

  vec_t vecs [6];

  pe_accumulator #(
    .IN_WIDTH  (16),
    .OUT_WIDTH (16),
    .GUARD     (8),
    .LEN_WIDTH (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .len        (len),
    .prod_in    (prod_in),
    .prod_valid (prod_valid),
    .stall_out  (stall_out),
    .res_out    (res_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .sat_flag   (sat_flag),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic [7:0] l, input logic [2:0] n,
                              input logic [15:0] t0, input logic [15:0] t1,
                              input logic [15:0] t2, input logic [15:0] t3,
                              input logic [15:0] r, input logic s);
    vec_t v;
    v.len      = l;
    v.n        = n;
    v.terms[0] = t0;
    v.terms[1] = t1;
    v.terms[2] = t2;
    v.terms[3] = t3;
    v.exp_res  = r;
    v.exp_sat  = s;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors_applied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic stepTerm(input logic v, input logic [15:0] d, input logic [7:0] l);
    @(negedge clk);
    prod_valid = v;
    prod_in    = d;
    len        = l;
  endtask

  task automatic finishHandshake();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checkOutput("post_handshake_busy", busy, 0);
    checkOutput("post_handshake_valid", res_valid, 0);
  endtask

  // Feeds one vector back to back, then checks the held result and its release.
  task automatic applyStimulus(input vec_t v);
    res_ready = 1'b0;
    for (int i = 0; i < int'(v.n); i++) begin
      @(negedge clk);
      if (i == int'(v.n) - 1) checkOutput("pre_last_valid", res_valid, 0);
      len        = v.len;
      prod_in    = v.terms[i];
      prod_valid = 1'b1;
    end
    @(negedge clk);
    prod_valid = 1'b0;
    checkOutput("res_valid", res_valid, 1);
    checkOutput("res_out", res_out, v.exp_res);
    checkOutput("sat_flag", sat_flag, v.exp_sat);
    checkOutput("busy_hold", busy, 1);
    checkOutput("stall_hold", stall_out, 1);
    res_ready = 1'b1;
    #1;
    checkOutput("stall_release", stall_out, 0);
    @(negedge clk);
    res_ready = 1'b0;
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_valid", res_valid, 0);
  endtask

  initial begin
    vecs[0] = mk(8'd2, 3'd2, 16'h7000, 16'h7000, 16'h0000, 16'h0000, 16'h7FFF, 1'b1);
    vecs[1] = mk(8'd3, 3'd3, 16'h8000, 16'h8000, 16'h8000, 16'h0000, 16'h8000, 1'b1);
    vecs[2] = mk(8'd4, 3'd4, 16'h0100, 16'h0200, 16'hFF00, 16'h0300, 16'h0500, 1'b0);
    vecs[3] = mk(8'd0, 3'd1, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 1'b0);
    vecs[4] = mk(8'd3, 3'd3, 16'h7000, 16'h7000, 16'h9000, 16'h0000, 16'h7000, 1'b0);
    vecs[5] = mk(8'd4, 3'd4, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFC00, 1'b0);

    reset      = 1'b1;
    clear      = 1'b0;
    len        = 8'd0;
    prod_in    = 16'h0000;
    prod_valid = 1'b0;
    res_ready  = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_res_valid", res_valid, 0);
    checkOutput("reset_res_out", res_out, 16'h0000);
    checkOutput("reset_stall", stall_out, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_sat", sat_flag, 0);
    reset = 1'b0;

    for (int k = 0; k < 6; k++) applyStimulus(vecs[k]);

    // Back-pressure: result held for three stalled cycles, next term waits.
    res_ready = 1'b0;
    stepTerm(1'b1, 16'h0011, 8'd1);
    stepTerm(1'b1, 16'h0022, 8'd1);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      checkOutput("bp_stall", stall_out, 1);
      checkOutput("bp_res_stable", res_out, 16'h0011);
    end
    @(negedge clk);
    res_ready = 1'b1;
    #1;
    checkOutput("bp_stall_release", stall_out, 0);
    checkOutput("bp_res_first", res_out, 16'h0011);
    @(negedge clk);
    prod_valid = 1'b0;
    checkOutput("bp_next_valid", res_valid, 1);
    checkOutput("bp_next_res", res_out, 16'h0022);
    finishHandshake();

    // Gapped input; len is latched with the first term and later len changes are ignored.
    stepTerm(1'b1, 16'h0100, 8'd3);
    stepTerm(1'b0, 16'hDEAD, 8'd1);
    checkOutput("gap_busy", busy, 1);
    checkOutput("gap_valid", res_valid, 0);
    stepTerm(1'b0, 16'hDEAD, 8'd1);
    stepTerm(1'b1, 16'h0200, 8'd1);
    stepTerm(1'b1, 16'h0300, 8'd1);
    stepTerm(1'b0, 16'h0000, 8'd0);
    checkOutput("gap_res_valid", res_valid, 1);
    checkOutput("gap_res_out", res_out, 16'h0600);
    finishHandshake();

    // Clear mid-vector with a concurrent term, then clear in IDLE with a term.
    stepTerm(1'b1, 16'h0100, 8'd4);
    stepTerm(1'b1, 16'h0100, 8'd4);
    @(negedge clk);
    clear = 1'b1; prod_valid = 1'b1; prod_in = 16'h0100;
    @(negedge clk);
    clear = 1'b0; prod_valid = 1'b0;
    checkOutput("clear_busy", busy, 0);
    checkOutput("clear_valid", res_valid, 0);
    checkOutput("clear_sat", sat_flag, 0);
    @(negedge clk);
    clear = 1'b1; prod_valid = 1'b1; prod_in = 16'h0500; len = 8'd1;
    @(negedge clk);
    clear = 1'b0; prod_valid = 1'b0;
    checkOutput("clear_drop_busy", busy, 0);
    checkOutput("clear_drop_valid", res_valid, 0);
    stepTerm(1'b1, 16'h0100, 8'd2);
    stepTerm(1'b1, 16'h0100, 8'd2);
    stepTerm(1'b0, 16'h0000, 8'd0);
    checkOutput("clear_next_valid", res_valid, 1);
    checkOutput("clear_next_res", res_out, 16'h0200);
    finishHandshake();

    // Reset while a result is held loses it; the next vector works normally.
    stepTerm(1'b1, 16'h0100, 8'd2);
    stepTerm(1'b1, 16'h0100, 8'd2);
    stepTerm(1'b0, 16'h0000, 8'd0);
    checkOutput("pre_reset_valid", res_valid, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("hold_reset_valid", res_valid, 0);
    checkOutput("hold_reset_stall", stall_out, 0);
    checkOutput("hold_reset_busy", busy, 0);
    checkOutput("hold_reset_res", res_out, 16'h0000);
    checkOutput("hold_reset_sat", sat_flag, 0);
    stepTerm(1'b1, 16'h0042, 8'd1);
    stepTerm(1'b0, 16'h0000, 8'd0);
    checkOutput("after_reset_valid", res_valid, 1);
    checkOutput("after_reset_res", res_out, 16'h0042);
    finishHandshake();

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
